sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO. Next generation of the team's 8x8 synchronous FIFO.
- Adds configurable width/depth, guarded read/write acceptance, registered read data with valid strobe, almost-full/almost-empty thresholds, occupancy output, sticky overflow/underflow error flags and a synchronous flush.
- Used as the general buffering primitive between producer/consumer blocks in one clock domain.

---
 rtl/sync_fifo_param.sv | 115 +++++++++++
 tb/tb_sync_fifo_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, threshold flags,
// sticky error flags and synchronous flush. Define SYNC_FIFO_PEAK_EN to add a peak_level high-water mark output.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              Write_En,
    input  logic [DATA_W-1:0] datain,
    input  logic              Read_En,
    output logic [DATA_W-1:0] dataout,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef SYNC_FIFO_PEAK_EN
    ,
    output logic [ADDR_W:0]   peak_level
`endif
);

    localparam int CW = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Flags decode only the registered count, so no enable reaches full/empty combinationally.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_acc = Read_En & ~empty;
    assign wr_acc = Write_En & (~full | rd_acc);

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear) begin
            mem[wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dataout   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                dataout <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (Write_En && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (Read_En && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_PEAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_level <= '0;
        end else if (clear) begin
            peak_level <= '0;
        end else if (count_nxt > peak_level) begin
            peak_level <= count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DATA_W=8, DEPTH=16.
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       Write_En;
    logic [7:0] datain;
    logic       Read_En;
    logic [7:0] dataout;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
`ifdef SYNC_FIFO_PEAK_EN
    logic [4:0] peak_level;
`endif

    int checks = 0;
    int passes = 0;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .Write_En(Write_En), .datain(datain), .Read_En(Read_En),
        .dataout(dataout), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
`ifdef SYNC_FIFO_PEAK_EN
        , .peak_level(peak_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        Write_En = 1'b0;
        Read_En  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            Write_En = 1'b1;
            datain   = base + 8'(i);
            step();
        end
        Write_En = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010)
            $display("FAIL reset_flags: got %b want 1010", {empty, full, almost_empty, almost_full}); else passes++;
        checks++; if ({rd_valid, overflow, underflow} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {rd_valid, overflow, underflow}); else passes++;
        checks++; if (dataout !== 8'h00) $display("FAIL reset_dataout: got %h want 00", dataout); else passes++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            Write_En = 1'b1;
            datain   = 8'(i);
            step();
            checks++; if (count !== 5'(i + 1)) $display("FAIL fill_count: got %0d want %0d", count, i + 1); else passes++;
            checks++; if ({almost_full, full} !== {(i + 1 >= 14), (i + 1 == 16)})
                $display("FAIL fill_af_full: got %b want %b", {almost_full, full}, {(i + 1 >= 14), (i + 1 == 16)}); else passes++;
        end
        Write_En = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Read_En = 1'b1;
            step();
            checks++; if (dataout !== 8'(i)) $display("FAIL drain_data: got %h want %h", dataout, 8'(i)); else passes++;
            checks++; if (rd_valid !== 1'b1) $display("FAIL drain_valid: got %b want 1", rd_valid); else passes++;
            checks++; if (almost_empty !== (15 - i <= 2))
                $display("FAIL drain_ae: got %b want %b", almost_empty, (15 - i <= 2)); else passes++;
        end
        Read_En = 1'b0;
        step();
        checks++; if ({empty, rd_valid} !== 2'b10) $display("FAIL drain_end: got %b want 10", {empty, rd_valid}); else passes++;
    endtask

    task automatic test_overflow();
        fill(8'h10, 16);
        Write_En = 1'b1;
        datain   = 8'hAA;
        step();
        Write_En = 1'b0;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
        checks++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count); else passes++;
        for (int i = 0; i < 16; i++) begin
            Read_En = 1'b1;
            step();
            checks++; if (dataout !== 8'h10 + 8'(i)) $display("FAIL ovf_data: got %h want %h", dataout, 8'h10 + 8'(i)); else passes++;
        end
        Read_En = 1'b0;
        step();
        checks++; if ({overflow, empty} !== 2'b11) $display("FAIL ovf_sticky: got %b want 11", {overflow, empty}); else passes++;
        do_clear();
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow); else passes++;
    endtask

    task automatic test_simul_full();
        fill(8'h20, 16);
        Write_En = 1'b1;
        Read_En  = 1'b1;
        datain   = 8'h55;
        step();
        Write_En = 1'b0;
        checks++; if (count !== 5'd16) $display("FAIL simul_count: got %0d want 16", count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL simul_ovf: got %b want 0", overflow); else passes++;
        checks++; if (dataout !== 8'h20) $display("FAIL simul_first: got %h want 20", dataout); else passes++;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (dataout !== ((i == 15) ? 8'h55 : 8'h21 + 8'(i)))
                $display("FAIL simul_data: got %h want %h", dataout, (i == 15) ? 8'h55 : 8'h21 + 8'(i)); else passes++;
        end
        Read_En = 1'b0;
        step();
        checks++; if (empty !== 1'b1) $display("FAIL simul_empty: got %b want 1", empty); else passes++;
    endtask

    task automatic test_underflow();
        Read_En = 1'b1;
        step();
        checks++; if (underflow !== 1'b1) $display("FAIL udf_flag: got %b want 1", underflow); else passes++;
        checks++; if (rd_valid !== 1'b0) $display("FAIL udf_valid: got %b want 0", rd_valid); else passes++;
        checks++; if (dataout !== 8'h55) $display("FAIL udf_hold: got %h want 55", dataout); else passes++;
        Write_En = 1'b1;
        datain   = 8'h33;
        step();
        Write_En = 1'b0;
        checks++; if (count !== 5'd1) $display("FAIL udf_both_count: got %0d want 1", count); else passes++;
        checks++; if ({underflow, rd_valid} !== 2'b10) $display("FAIL udf_both_flags: got %b want 10", {underflow, rd_valid}); else passes++;
        step();
        Read_En = 1'b0;
        checks++; if ({dataout, rd_valid} !== {8'h33, 1'b1}) $display("FAIL udf_readback: got %h/%b want 33/1", dataout, rd_valid); else passes++;
        do_clear();
        checks++; if (underflow !== 1'b0) $display("FAIL udf_cleared: got %b want 0", underflow); else passes++;
    endtask

    task automatic test_wrap();
        fill(8'h40, 3);
        for (int k = 0; k < 40; k++) begin
            Write_En = 1'b1;
            Read_En  = 1'b1;
            datain   = 8'h43 + 8'(k);
            step();
            checks++; if (dataout !== 8'h40 + 8'(k)) $display("FAIL wrap_data: got %h want %h", dataout, 8'h40 + 8'(k)); else passes++;
            checks++; if (count !== 5'd3) $display("FAIL wrap_count: got %0d want 3", count); else passes++;
        end
        Write_En = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (dataout !== 8'h68 + 8'(k)) $display("FAIL wrap_tail: got %h want %h", dataout, 8'h68 + 8'(k)); else passes++;
        end
        Read_En = 1'b0;
        step();
        checks++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passes++;
    endtask

    task automatic test_clear();
        do_clear();
        Read_En = 1'b1;
        step();
        Read_En = 1'b0;
        fill(8'h80, 9);
        checks++; if ({count, underflow} !== {5'd9, 1'b1}) $display("FAIL clr_pre: got %0d/%b want 9/1", count, underflow); else passes++;
`ifdef SYNC_FIFO_PEAK_EN
        checks++; if (peak_level !== 5'd9) $display("FAIL clr_peak_pre: got %0d want 9", peak_level); else passes++;
`endif
        clear    = 1'b1;
        Write_En = 1'b1;
        datain   = 8'h99;
        step();
        clear    = 1'b0;
        Write_En = 1'b0;
        checks++; if ({count, empty} !== {5'd0, 1'b1}) $display("FAIL clr_count: got %0d/%b want 0/1", count, empty); else passes++;
        checks++; if ({overflow, underflow, rd_valid, almost_full} !== 4'b0000)
            $display("FAIL clr_flags: got %b want 0000", {overflow, underflow, rd_valid, almost_full}); else passes++;
        checks++; if (dataout !== 8'h6A) $display("FAIL clr_dataout: got %h want 6a", dataout); else passes++;
`ifdef SYNC_FIFO_PEAK_EN
        checks++; if (peak_level !== 5'd0) $display("FAIL clr_peak_post: got %0d want 0", peak_level); else passes++;
`endif
        step();
        checks++; if (count !== 5'd0) $display("FAIL clr_write_dropped: got %0d want 0", count); else passes++;
    endtask

    task automatic test_async_reset();
        fill(8'h70, 5);
        Read_En = 1'b1;
        step();
        Read_En = 1'b0;
        checks++; if ({dataout, count} !== {8'h70, 5'd4}) $display("FAIL ar_pre: got %h/%0d want 70/4", dataout, count); else passes++;
        Write_En = 1'b1;
        datain   = 8'h75;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({count, empty, almost_empty} !== {5'd0, 1'b1, 1'b1})
            $display("FAIL ar_count: got %0d/%b/%b want 0/1/1", count, empty, almost_empty); else passes++;
        checks++; if ({dataout, rd_valid, overflow, underflow} !== {8'h00, 3'b000})
            $display("FAIL ar_outputs: got %h/%b want 00/000", dataout, {rd_valid, overflow, underflow}); else passes++;
`ifdef SYNC_FIFO_PEAK_EN
        checks++; if (peak_level !== 5'd0) $display("FAIL ar_peak: got %0d want 0", peak_level); else passes++;
`endif
        @(negedge clk);
        idle();
        reset = 1'b1;
        Read_En = 1'b1;
        step();
        Read_En = 1'b0;
        checks++; if ({underflow, rd_valid, count} !== {2'b10, 5'd0})
            $display("FAIL ar_data_lost: got %b/%b/%0d want 1/0/0", underflow, rd_valid, count); else passes++;
    endtask

    initial begin
        reset  = 1'b0;
        datain = 8'h00;
        idle();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_underflow();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
